// File: rtl/user_edge_pkg.sv
// user_edge_pkg: register map, FSM states, image geometry and OBI types for the edge engine
package user_edge_pkg;

    localparam int ImgDim = 16;
    localparam int NumPix = ImgDim * ImgDim;
    localparam logic [3:0] LastPos = 4'(ImgDim - 1);

    localparam logic [5:0] OffCtrl      = 6'h00;
    localparam logic [5:0] OffStatus    = 6'h04;
    localparam logic [5:0] OffThresh    = 6'h08;
    localparam logic [5:0] OffCount     = 6'h0C;
    localparam logic [5:0] OffBitmap    = 6'h10;
    localparam logic [5:0] OffBitmapEnd = 6'h2C;

    localparam int CtrlStartBit  = 0;
    localparam int StatusBusyBit = 0;
    localparam int StatusDoneBit = 1;

    typedef enum logic [2:0] {IDLE, SCAN, FETCH, CALC, FINISH} state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aid;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } obi_rsp_t;

    // Neighbour k of pixel idx in fetch order: 0=left, 1=right, 2=up, 3=down
    function automatic logic [31:0] nbr_addr(input logic [7:0] idx, input logic [1:0] k);
        return {24'h0,
                k == 2'd2 ? idx[7:4] - 4'd1 : k == 2'd3 ? idx[7:4] + 4'd1 : idx[7:4],
                k == 2'd0 ? idx[3:0] - 4'd1 : k == 2'd1 ? idx[3:0] + 4'd1 : idx[3:0]};
    endfunction

endpackage

// File: rtl/user_edge_regs.sv
// user_edge_regs: OBI register file holding threshold, status, edge count and edge bitmap
module user_edge_regs
    import user_edge_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   obi_req_i,
    output obi_rsp_t   obi_rsp_o,
    input  logic       upd,
    input  logic [7:0] idx,
    input  logic       hit,
    input  logic       fin,
    output logic       start,
    output logic       busy,
    output logic [8:0] thresh
);

    logic         done;
    logic [8:0]   count;
    logic [255:0] bitmap;
    logic         rvalid_q, rid_q, err_q;
    logic [31:0]  rdata_q;
    logic [5:0]   off;
    logic [2:0]   w;
    logic         wr, is_bm, known, err, thr_wr;
    logic [31:0]  rd;
    logic         unused_bits;

    assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:6], obi_req_i.wdata[31:9]};

    // Address decode, read mux and access-error classification
    always_comb begin
        off = obi_req_i.addr[5:0];
        wr = obi_req_i.we;
        is_bm = off >= OffBitmap && off <= OffBitmapEnd && off[1:0] == 2'b00;
        w = 3'(off[5:2] - 4'd4);
        known = off == OffCtrl || off == OffStatus || off == OffThresh || off == OffCount || is_bm;
        rd = off == OffStatus ? {30'b0, done, busy} :
             off == OffThresh ? {23'b0, thresh} :
             off == OffCount  ? {23'b0, count} :
             is_bm            ? bitmap[{w, 5'b0} +: 32] : 32'b0;
        err = !known || (wr && (off == OffStatus || off == OffCount || is_bm || (off == OffThresh && busy)));
        start = obi_req_i.req && wr && off == OffCtrl && obi_req_i.wdata[CtrlStartBit] && !busy;
        thr_wr = obi_req_i.req && wr && off == OffThresh && !busy;
        obi_rsp_o = '{gnt: obi_req_i.req, rvalid: rvalid_q, rdata: rdata_q, rid: rid_q, err: err_q};
    end

    // Registered response plus register/result storage updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q <= '0;
            rid_q <= 1'b0;
            err_q <= 1'b0;
            thresh <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            count <= '0;
            bitmap <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                rdata_q <= wr ? 32'b0 : rd;
                rid_q <= obi_req_i.aid;
                err_q <= err;
            end
            if (thr_wr) thresh <= obi_req_i.wdata[8:0];
            if (start) begin
                busy <= 1'b1;
                done <= 1'b0;
                count <= '0;
                bitmap <= '0;
            end else begin
                if (upd) begin
                    bitmap[idx] <= hit;
                    count <= count + 9'(hit);
                end
                if (fin) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/user_edge_engine.sv
// user_edge_engine: scans a 16x16 image via the ROM accel port and builds a thresholded edge bitmap
module user_edge_engine
    import user_edge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    obi_req_i,
    output obi_rsp_t    obi_rsp_o,
    output logic        accel_req_o,
    output logic [31:0] accel_addr_o,
    input  logic [7:0]  accel_data_i,
    input  logic        accel_valid_i,
    output logic        irq_o
);

    state_e          state;
    logic [7:0]      idx;
    logic [1:0]      fcnt;
    logic [2:0]      vcnt;
    logic [3:0][7:0] pix;
    logic            start, busy, border, got, hit, adv, fin;
    logic [8:0]      thresh, gx, gy, mag;
    logic [7:0]      d_px;

    user_edge_regs u_regs (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .obi_req_i (obi_req_i),
        .obi_rsp_o (obi_rsp_o),
        .upd       (got),
        .idx       (idx),
        .hit       (hit),
        .fin       (fin),
        .start     (start),
        .busy      (busy),
        .thresh    (thresh)
    );

    // Gradient datapath; the down pixel is taken straight off the bus when it is the 4th return
    always_comb begin
        border = idx[7:4] == 4'h0 || idx[7:4] == LastPos || idx[3:0] == 4'h0 || idx[3:0] == LastPos;
        d_px = vcnt == 3'd3 ? accel_data_i : pix[3];
        gx = {1'b0, pix[1]} - {1'b0, pix[0]};
        gy = {1'b0, d_px} - {1'b0, pix[2]};
        mag = (gx[8] ? -gx : gx) + (gy[8] ? -gy : gy);
        hit = mag > thresh;
        got = state == CALC && (vcnt == 3'd4 || (vcnt == 3'd3 && accel_valid_i));
        adv = (state == SCAN && border) || got;
        fin = adv && idx == 8'hFF;
    end

    // Scan FSM: CALC also absorbs the wait for late ROM returns, so it is one cycle with a 1-cycle ROM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx <= '0;
            fcnt <= '0;
            vcnt <= '0;
            pix <= '0;
            accel_req_o <= 1'b0;
            accel_addr_o <= '0;
            irq_o <= 1'b0;
        end else begin
            irq_o <= fin;
            if (accel_valid_i && (state == FETCH || state == CALC) && !vcnt[2]) begin
                pix[vcnt[1:0]] <= accel_data_i;
                vcnt <= vcnt + 3'd1;
            end
            if (start) begin
                state <= SCAN;
                idx <= '0;
            end else begin
                case (state)
                    SCAN:
                        if (border) begin
                            idx <= idx + 8'd1;
                            state <= idx == 8'hFF ? FINISH : SCAN;
                        end else begin
                            state <= FETCH;
                            fcnt <= '0;
                            vcnt <= '0;
                            accel_req_o <= 1'b1;
                            accel_addr_o <= nbr_addr(idx, 2'd0);
                        end
                    FETCH: begin
                        fcnt <= fcnt + 2'd1;
                        if (fcnt == 2'd3) begin
                            accel_req_o <= 1'b0;
                            state <= CALC;
                        end else begin
                            accel_addr_o <= nbr_addr(idx, fcnt + 2'd1);
                        end
                    end
                    CALC:
                        if (got) begin
                            idx <= idx + 8'd1;
                            state <= idx == 8'hFF ? FINISH : SCAN;
                        end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_user_edge_engine.sv
// tb_user_edge_engine: directed checks of the edge engine against a col-valued ROM model
module tb_user_edge_engine;
    import user_edge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    obi_req_t    req;
    obi_rsp_t    rsp;
    logic        accel_req, accel_valid, irq;
    logic [31:0] accel_addr;
    logic [7:0]  accel_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    logic [7:0]  vq;
    logic [7:0]  dq [8];
    logic [31:0] rd;
    logic        er;
    int          n;

    always #5 clk = ~clk;

    user_edge_engine dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .obi_req_i     (req),
        .obi_rsp_o     (rsp),
        .accel_req_o   (accel_req),
        .accel_addr_o  (accel_addr),
        .accel_data_i  (accel_data),
        .accel_valid_i (accel_valid),
        .irq_o         (irq)
    );

    // ROM model: pixel value = column, returned lat cycles after the request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= '0;
        end else begin
            vq <= {vq[6:0], accel_req};
            dq[0] <= {4'h0, accel_addr[3:0]};
            for (int i = 1; i < 8; i++) dq[i] <= dq[i-1];
        end
    end
    assign accel_valid = vq[3'(lat - 1)];
    assign accel_data = dq[3'(lat - 1)];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input int w, input bit on);
        logic [31:0] v;
        int p, r, c;
        v = '0;
        for (int b = 0; b < 32; b++) begin
            p = 32 * w + b;
            r = p / 16;
            c = p % 16;
            v[b] = on && r > 0 && r < 15 && c > 0 && c < 15;
        end
        return v;
    endfunction

    task automatic obi(input logic we, input logic [5:0] a, input logic [31:0] wd,
                       output logic [31:0] rdat, output logic erf);
        @(negedge clk);
        req.req = 1'b1;
        req.we = we;
        req.be = 4'hF;
        req.addr = {26'h0, a};
        req.wdata = wd;
        req.aid = 1'b0;
        @(posedge clk);
        #1;
        req.req = 1'b0;
        rdat = rsp.rvalid ? rsp.rdata : 32'hBAD0_BAD0;
        erf = rsp.rvalid ? rsp.err : 1'bx;
    endtask

    task automatic wait_irq(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (irq) break;
        end
        if (!irq) cycles = -1;
    endtask

    task automatic test_reset;
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (accel_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", accel_req); end
        n_cmp++; if (accel_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", accel_addr); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
        n_cmp++; if (rsp !== '0) begin n_bad++; $display("FAIL rst_rsp: got %h want 0", rsp); end
        obi(1'b0, OffStatus, 0, rd, er);
        n_cmp++; if ({er, rd} !== 33'h0) begin n_bad++; $display("FAIL rst_status: got err=%b data=%h want 0/0", er, rd); end
        obi(1'b0, OffThresh, 0, rd, er);
        n_cmp++; if ({er, rd} !== 33'h0) begin n_bad++; $display("FAIL rst_thresh: got err=%b data=%h want 0/0", er, rd); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if ({er, rd} !== 33'h0) begin n_bad++; $display("FAIL rst_count: got err=%b data=%h want 0/0", er, rd); end
        for (int w = 0; w < 8; w++) begin
            obi(1'b0, 6'(OffBitmap + 4 * w), 0, rd, er);
            n_cmp++; if ({er, rd} !== 33'h0) begin n_bad++; $display("FAIL rst_bitmap%0d: got err=%b data=%h want 0/0", w, er, rd); end
        end
    endtask

    task automatic test_scan_thresh1;
        obi(1'b1, OffThresh, 1, rd, er);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL t2_thr_wr: got err=%b want 0", er); end
        obi(1'b1, OffCtrl, 1, rd, er);
        wait_irq(3000, n);
        n_cmp++; if (n !== 1236) begin n_bad++; $display("FAIL t2_cycles: got %0d want 1236", n); end
        @(posedge clk);
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_pulse: got %b want 0", irq); end
        obi(1'b0, OffStatus, 0, rd, er);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL t2_status: got %h want 2", rd); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'd196) begin n_bad++; $display("FAIL t2_count: got %0d want 196", rd); end
        obi(1'b0, OffBitmap, 0, rd, er);
        n_cmp++; if (rd !== 32'h7FFE0000) begin n_bad++; $display("FAIL t2_bitmap0: got %h want 7ffe0000", rd); end
        obi(1'b0, 6'h1C, 0, rd, er);
        n_cmp++; if (rd !== 32'h7FFE7FFE) begin n_bad++; $display("FAIL t2_bitmap3: got %h want 7ffe7ffe", rd); end
        obi(1'b0, OffBitmapEnd, 0, rd, er);
        n_cmp++; if (rd !== 32'h00007FFE) begin n_bad++; $display("FAIL t2_bitmap7: got %h want 00007ffe", rd); end
    endtask

    task automatic test_thresh_strict;
        obi(1'b1, OffThresh, 2, rd, er);
        obi(1'b1, OffCtrl, 1, rd, er);
        wait_irq(3000, n);
        n_cmp++; if (n !== 1236) begin n_bad++; $display("FAIL t3_cycles: got %0d want 1236", n); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL t3_count: got %0d want 0", rd); end
        for (int w = 0; w < 8; w++) begin
            obi(1'b0, 6'(OffBitmap + 4 * w), 0, rd, er);
            n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL t3_bitmap%0d: got %h want 0", w, rd); end
        end
    endtask

    task automatic test_busy_errors;
        obi(1'b1, OffThresh, 1, rd, er);
        obi(1'b1, OffCtrl, 1, rd, er);
        obi(1'b1, OffCtrl, 1, rd, er);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL t4_restart_err: got %b want 0", er); end
        obi(1'b1, OffThresh, 5, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL t4_thr_busy_err: got %b want 1", er); end
        obi(1'b1, OffStatus, 3, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL t4_status_wr_err: got %b want 1", er); end
        obi(1'b0, 6'h30, 0, rd, er);
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL t4_bad_off: got err=%b data=%h want 1/0", er, rd); end
        obi(1'b0, OffStatus, 0, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'h1}) begin n_bad++; $display("FAIL t4_status_busy: got err=%b data=%h want 0/1", er, rd); end
        wait_irq(3000, n);
        n_cmp++; if (n !== 1231) begin n_bad++; $display("FAIL t4_cycles: got %0d want 1231", n); end
        obi(1'b0, OffThresh, 0, rd, er);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL t4_thresh: got %0d want 1", rd); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'd196) begin n_bad++; $display("FAIL t4_count: got %0d want 196", rd); end
        for (int w = 0; w < 8; w++) begin
            obi(1'b0, 6'(OffBitmap + 4 * w), 0, rd, er);
            n_cmp++; if (rd !== exp_word(w, 1'b1)) begin n_bad++; $display("FAIL t4_bitmap%0d: got %h want %h", w, rd, exp_word(w, 1'b1)); end
        end
    endtask

    task automatic test_reset_midscan;
        obi(1'b1, OffCtrl, 1, rd, er);
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({accel_req, accel_addr, irq, rsp.rvalid} !== '0) begin n_bad++; $display("FAIL t5_rst_outputs: got req=%b addr=%h irq=%b rvalid=%b want 0", accel_req, accel_addr, irq, rsp.rvalid); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obi(1'b0, OffStatus, 0, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL t5_status: got %h want 0", rd); end
        obi(1'b0, OffThresh, 0, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL t5_thresh: got %h want 0", rd); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL t5_count: got %h want 0", rd); end
        obi(1'b1, OffThresh, 1, rd, er);
        obi(1'b1, OffCtrl, 1, rd, er);
        wait_irq(3000, n);
        n_cmp++; if (n !== 1236) begin n_bad++; $display("FAIL t5_cycles: got %0d want 1236", n); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'd196) begin n_bad++; $display("FAIL t5_count_after: got %0d want 196", rd); end
        for (int w = 0; w < 8; w++) begin
            obi(1'b0, 6'(OffBitmap + 4 * w), 0, rd, er);
            n_cmp++; if (rd !== exp_word(w, 1'b1)) begin n_bad++; $display("FAIL t5_bitmap%0d: got %h want %h", w, rd, exp_word(w, 1'b1)); end
        end
    endtask

    task automatic test_delayed_valid;
        lat = 4;
        obi(1'b1, OffCtrl, 1, rd, er);
        wait_irq(5000, n);
        n_cmp++; if (n !== 1824) begin n_bad++; $display("FAIL t6_cycles: got %0d want 1824", n); end
        obi(1'b0, OffStatus, 0, rd, er);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL t6_status: got %h want 2", rd); end
        obi(1'b0, OffCount, 0, rd, er);
        n_cmp++; if (rd !== 32'd196) begin n_bad++; $display("FAIL t6_count: got %0d want 196", rd); end
        for (int w = 0; w < 8; w++) begin
            obi(1'b0, 6'(OffBitmap + 4 * w), 0, rd, er);
            n_cmp++; if (rd !== exp_word(w, 1'b1)) begin n_bad++; $display("FAIL t6_bitmap%0d: got %h want %h", w, rd, exp_word(w, 1'b1)); end
        end
        lat = 1;
    endtask

    initial begin
        test_reset;
        test_scan_thresh1;
        test_thresh_strict;
        test_busy_errors;
        test_reset_midscan;
        test_delayed_valid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
